// File: rtl/dsp_drain_ctr.sv
// ============================================================================
// Module      : dsp_drain_ctr
// Description : Loadable down-counter that drains a programmed beat count.
//               Presents indices start_val-1 .. 0 on a valid/ready stream,
//               then pulses done for one cycle. Used for read-out / unload
//               sequencing of buffers on the consumer side of address and
//               length generation.
// Options     : DSP_DRAIN_BEAT_CNT_EN - adds the beat_cnt output (beats
//               accepted in the current run).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_drain_ctr #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [COUNTER_WIDTH-1:0] start_val,
  input  logic                     load,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [COUNTER_WIDTH-1:0] ctr_val,
  output logic                     last,
  output logic                     done,
  output logic                     busy
`ifdef DSP_DRAIN_BEAT_CNT_EN
  ,
  output logic [COUNTER_WIDTH-1:0] beat_cnt
`endif
);

  // Adding all-ones is a modulo decrement; keeps the adder a plain A+B
  // so it maps onto a DSP slice.
  localparam logic [COUNTER_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [COUNTER_WIDTH-1:0] ONE      = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] pipe;       // captured start_val (input pipe)
  (* use_dsp = "yes" *)
  logic [COUNTER_WIDTH-1:0] count;      // current index, registered adder output
  logic [COUNTER_WIDTH-1:0] dec_a;      // adder operand: pipe in ARM, count otherwise
  logic [COUNTER_WIDTH-1:0] dec_sum;    // dec_a - 1 (mod 2^W)
  logic                     beat;
  logic                     count_zero;
  logic                     pipe_zero;

  // A beat needs the global advance as well as the handshake.
  assign beat       = out_valid & out_ready & enable;
  assign count_zero = (count == '0);
  assign pipe_zero  = (pipe == '0);

  // Shared decrement datapath: ARM preloads pipe-1, RUN steps count-1.
  assign dec_a   = (state == ARM) ? pipe : count;
  assign dec_sum = dec_a + ALL_ONES;

  // ctr_val is the count register itself; it simply holds outside RUN.
  assign ctr_val = count;
  // last follows the registered count, qualified by valid.
  assign last    = out_valid & count_zero;

  // Control FSM and datapath registers; enable=0 freezes everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pipe      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else if (enable) begin
      if (load) begin
        // Start, or abort-and-restart: the old run never reports done.
        pipe      <= start_val;
        state     <= ARM;
        out_valid <= 1'b0;
        done      <= 1'b0;
        busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
          end
          ARM: begin
            count <= dec_sum;
            busy  <= 1'b1;
            if (pipe_zero) begin
              // Zero-length drain: no beats, but done still pulses.
              state     <= DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              state     <= RUN;
              out_valid <= 1'b1;
              done      <= 1'b0;
            end
          end
          RUN: begin
            if (beat) begin
              if (count_zero) begin
                // Final beat taken; never step below zero.
                state     <= DONE;
                out_valid <= 1'b0;
                done      <= 1'b1;
              end else begin
                count <= dec_sum;
              end
            end
          end
          DONE: begin
            state     <= IDLE;
            out_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
          end
          default: begin
            state     <= IDLE;
            out_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DSP_DRAIN_BEAT_CNT_EN
  // Beats accepted in the current run; cleared by any accepted load.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (enable) begin
      if (load) begin
        beat_cnt <= '0;
      end else if (state == RUN && beat) begin
        beat_cnt <= beat_cnt + ONE;
      end
    end
  end
`else
  // Without the beat counter the constant is not needed.
  logic unused_one;
  assign unused_one = ^ONE;
`endif

endmodule

`default_nettype wire
